// File: rtl/id_pair_packer_if.sv
// Pair-input / packed-word-output bundle for id_pair_packer.
// slave = the packer, master = whoever feeds pairs and consumes words.
interface id_pair_packer_if #(
    parameter int BUS_WIDTH    = 512,
    parameter int VEC_ID_WIDTH = 10
);
    localparam int PAIR_WIDTH     = 2 * VEC_ID_WIDTH;
    localparam int PAIRS_PER_WORD = BUS_WIDTH / PAIR_WIDTH;
    localparam int CNT_W          = $clog2(PAIRS_PER_WORD + 1);

    logic                  i_IDPair_Ready;
    logic [PAIR_WIDTH-1:0] i_IDPair_Out;
    logic                  i_IDPair_Last;
    logic                  o_IDPair_Read;
    logic                  i_Flush;
    logic [BUS_WIDTH-1:0]  o_Word;
    logic                  o_WordValid;
    logic                  i_WordReady;
    logic [CNT_W-1:0]      o_WordPairCnt;
    logic                  o_WordLast;
    logic [31:0]           o_TotalPairs;

    modport slave (
        input  i_IDPair_Ready, i_IDPair_Out, i_IDPair_Last, i_Flush, i_WordReady,
        output o_IDPair_Read, o_Word, o_WordValid, o_WordPairCnt, o_WordLast, o_TotalPairs
    );

    modport master (
        output i_IDPair_Ready, i_IDPair_Out, i_IDPair_Last, i_Flush, i_WordReady,
        input  o_IDPair_Read, o_Word, o_WordValid, o_WordPairCnt, o_WordLast, o_TotalPairs
    );
endinterface

// File: rtl/id_pair_packer.sv
// Packs (ref ID, cmp ID) pairs densely into BUS_WIDTH-bit words with count/last.
// Optional: define ID_PAIR_PACKER_TOTAL_CNT_EN to build the saturating accepted-pair counter.
module id_pair_packer #(
    parameter int BUS_WIDTH    = 512,
    parameter int VEC_ID_WIDTH = 10
) (
    input  logic               clk,
    input  logic               rstn,
    id_pair_packer_if.slave    bus
);
    localparam int PAIR_WIDTH     = 2 * VEC_ID_WIDTH;
    localparam int PAIRS_PER_WORD = BUS_WIDTH / PAIR_WIDTH;
    localparam int CNT_W          = $clog2(PAIRS_PER_WORD + 1);

    logic [BUS_WIDTH-1:0] asm_word;
    logic [CNT_W-1:0]     asm_cnt;
    logic                 asm_last;
    logic                 asm_done;

    logic [BUS_WIDTH-1:0] out_word;
    logic [CNT_W-1:0]     out_cnt;
    logic                 out_last;
    logic                 out_valid;

    logic accept;
    logic flush;
    logic transfer;
    logic word_full;

    // Read depends on state only, so acceptance and transfer never coincide.
    assign bus.o_IDPair_Read = !asm_done;
    assign accept    = !asm_done && bus.i_IDPair_Ready;
    assign flush     = !asm_done && bus.i_Flush;
    assign transfer  = asm_done && (!out_valid || bus.i_WordReady);
    assign word_full = (asm_cnt == CNT_W'(PAIRS_PER_WORD - 1));

    // NOTE: every register below uses non-blocking assignment so all state
    // updates see the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: the wide assembly word is reset too; unused slots and the top
            // pad bits rely on it starting at zero rather than being masked later.
            asm_word <= '0;
            asm_cnt  <= '0;
            asm_last <= 1'b0;
            asm_done <= 1'b0;
        end else if (transfer) begin
            asm_word <= '0;
            asm_cnt  <= '0;
            asm_last <= 1'b0;
            asm_done <= 1'b0;
        end else if (accept) begin
            for (int k = 0; k < PAIRS_PER_WORD; k++) begin
                if (asm_cnt == CNT_W'(k)) begin
                    asm_word[k*PAIR_WIDTH +: PAIR_WIDTH] <= bus.i_IDPair_Out;
                end
            end
            asm_cnt  <= asm_cnt + 1'b1;
            asm_done <= word_full || bus.i_IDPair_Last || bus.i_Flush;
            asm_last <= bus.i_IDPair_Last || bus.i_Flush;
        end else if (flush) begin
            asm_done <= 1'b1;
            asm_last <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_word  <= '0;
            out_cnt   <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (transfer) begin
            out_word  <= asm_word;
            out_cnt   <= asm_cnt;
            out_last  <= asm_last;
            out_valid <= 1'b1;
        end else if (out_valid && bus.i_WordReady) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.o_Word        = out_word;
    assign bus.o_WordPairCnt = out_cnt;
    assign bus.o_WordLast    = out_last;
    assign bus.o_WordValid   = out_valid;

`ifdef ID_PAIR_PACKER_TOTAL_CNT_EN
    logic [31:0] total_pairs;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            total_pairs <= '0;
        end else if (accept && (total_pairs != 32'hFFFF_FFFF)) begin
            total_pairs <= total_pairs + 32'd1;
        end
    end

    assign bus.o_TotalPairs = total_pairs;
`else
    assign bus.o_TotalPairs = 32'd0;
`endif
endmodule

// File: tb/tb_id_pair_packer.sv
// Directed bench for id_pair_packer: a reference packer model fills a scoreboard
// queue as pairs are accepted; a monitor pops and compares each delivered word.
module tb_id_pair_packer;
    localparam int BW  = 512;
    localparam int PW  = 20;
    localparam int PPW = 25;

    typedef struct {
        logic [BW-1:0] word;
        int            cnt;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    int   checks   = 0;
    int   failures = 0;

    exp_t          exp_q[$];
    logic [BW-1:0] m_word;
    int            m_cnt;

    id_pair_packer_if #(.BUS_WIDTH(BW), .VEC_ID_WIDTH(10)) bus ();

    id_pair_packer #(.BUS_WIDTH(BW), .VEC_ID_WIDTH(10)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_word = '0;
        m_cnt  = 0;
    endtask

    task automatic model_close(input logic last);
        exp_t e;
        e.word = m_word;
        e.cnt  = m_cnt;
        e.last = last;
        exp_q.push_back(e);
        model_clear();
    endtask

    task automatic model_add(input logic [PW-1:0] pair, input logic last);
        m_word[m_cnt*PW +: PW] = pair;
        m_cnt++;
        if (m_cnt == PPW || last) model_close(last);
    endtask

    // Offers one pair from posedge+1 and returns once it has been accepted.
    task automatic send_pair(input logic [PW-1:0] pair, input logic last);
        logic rd;
        logic done = 1'b0;
        bus.i_IDPair_Ready = 1'b1;
        bus.i_IDPair_Out   = pair;
        bus.i_IDPair_Last  = last;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            rd = bus.o_IDPair_Read;
            @(posedge clk);
            #1;
            if (rd) begin
                model_add(pair, last);
                done = 1'b1;
            end
        end
        check("pair_accept_timeout", {511'd0, done}, {511'd0, 1'b1});
        bus.i_IDPair_Ready = 1'b0;
        bus.i_IDPair_Last  = 1'b0;
    endtask

    task automatic send_flush();
        logic rd;
        bus.i_Flush = 1'b1;
        @(negedge clk);
        rd = bus.o_IDPair_Read;
        @(posedge clk);
        #1;
        bus.i_Flush = 1'b0;
        check("flush_sampled", {511'd0, rd}, {511'd0, 1'b1});
        if (rd) model_close(1'b1);
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 500 && exp_q.size() != 0; c++) @(posedge clk);
        #1;
        check("drain_left", BW'(exp_q.size()), '0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, {511'd0, bus.o_WordValid}, '0);
        check({tag, "_word"}, bus.o_Word, '0);
        check({tag, "_cnt"}, BW'(bus.o_WordPairCnt), '0);
        check({tag, "_last"}, {511'd0, bus.o_WordLast}, '0);
        check({tag, "_total"}, BW'(bus.o_TotalPairs), '0);
        check({tag, "_read"}, {511'd0, bus.o_IDPair_Read}, {511'd0, 1'b1});
    endtask

    // Monitor: a word handshake completes at the next posedge, so sample at negedge.
    always @(negedge clk) begin
        if (rstn && bus.o_WordValid && bus.i_WordReady) begin
            exp_t e;
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_word observed_cnt=%0d expected=none", bus.o_WordPairCnt);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("word_data", bus.o_Word, e.word);
                check("word_cnt", BW'(bus.o_WordPairCnt), BW'(e.cnt));
                check("word_last", {511'd0, bus.o_WordLast}, {511'd0, e.last});
                check("word_pad_zero", BW'(bus.o_Word[BW-1:PPW*PW]), '0);
            end
        end
    end

    initial begin
        logic [PW-1:0] pairs [60];
        int            acc;
        logic          rd;

        model_clear();
        rstn               = 1'b0;
        bus.i_IDPair_Ready = 1'b0;
        bus.i_IDPair_Out   = '0;
        bus.i_IDPair_Last  = 1'b0;
        bus.i_Flush        = 1'b0;
        bus.i_WordReady    = 1'b1;
        #2;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Full word closed by the last flag on pair 25.
        for (int i = 0; i < 25; i++) send_pair(PW'($urandom), i == 24);
        wait_drain();

        // 26 pairs: full word without last, then a single-pair last word.
        for (int i = 0; i < 26; i++) send_pair(PW'($urandom), i == 25);
        wait_drain();

        // Stalled consumer: exactly two words' worth of pairs absorbed.
        for (int i = 0; i < 60; i++) pairs[i] = PW'($urandom);
        bus.i_WordReady = 1'b0;
        acc = 0;
        for (int c = 0; c < 200; c++) begin
            bus.i_IDPair_Ready = 1'b1;
            bus.i_IDPair_Out   = pairs[acc];
            bus.i_IDPair_Last  = (acc == 59);
            @(negedge clk);
            rd = bus.o_IDPair_Read;
            @(posedge clk);
            #1;
            if (rd) begin
                model_add(pairs[acc], acc == 59);
                acc++;
            end
        end
        bus.i_IDPair_Ready = 1'b0;
        bus.i_IDPair_Last  = 1'b0;
        check("stall_accepted", BW'(acc), BW'(50));
        check("stall_read_low", {511'd0, bus.o_IDPair_Read}, '0);
        check("stall_valid_held", {511'd0, bus.o_WordValid}, {511'd0, 1'b1});
        bus.i_WordReady = 1'b1;
        for (int i = 50; i < 60; i++) send_pair(pairs[i], i == 59);
        wait_drain();

        // Flush of an empty job, then a flush closing a 12-pair word.
        send_flush();
        wait_drain();
        for (int i = 0; i < 12; i++) send_pair(PW'($urandom), 1'b0);
        send_flush();
        wait_drain();

        // Reset mid-word discards the partial word.
        for (int i = 0; i < 7; i++) send_pair(PW'($urandom), 1'b0);
        rstn = 1'b0;
        #2;
        check_reset_outputs("midreset");
        model_clear();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) send_pair(PW'($urandom), 1'b0);
        send_flush();
        wait_drain();
`ifdef ID_PAIR_PACKER_TOTAL_CNT_EN
        check("total_after_reset", BW'(bus.o_TotalPairs), BW'(3));
`else
        check("total_after_reset", BW'(bus.o_TotalPairs), '0);
`endif

        repeat (5) @(posedge clk);
        check("no_extra_words", BW'(exp_q.size()), '0);
        check("idle_valid", {511'd0, bus.o_WordValid}, '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
